// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_pkg
// Description : Shared constants and state encodings for the debug UART
//               transmitter. Holds the frame sync byte, the number of debug
//               bytes per frame, the frame-level state enum and the per-byte
//               serializer state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_pkg;

    localparam int         NUM_PORTS = 7;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Frame sequencing: wait for trigger, stream 9 bytes, one-cycle completion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } frame_state_t;

    // Serializer position within a single 8N1 byte
    typedef enum logic [1:0] {
        START = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2
    } byte_state_t;

endpackage
`default_nettype wire

// File: rtl/debug_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 UART byte serializer, LSB first, line idles high.
//               Accepts a byte on valid & ready. ready is also raised in the
//               final cycle of the stop bit so a waiting byte's start bit
//               follows immediately with no idle gap.
// Ports       : clk, reset (sync, active-high), data[7:0], valid  -> inputs
//               ready, tx                                         -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    byte_state_t         r_state;
    logic                r_active;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_data;

    byte_state_t         w_state_nxt;
    logic                w_active_nxt;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic [2:0]          w_bit_idx_nxt;
    logic [7:0]          w_data_nxt;
    logic                w_wrap;
    logic                w_accept;
    logic                w_tx;

    assign w_wrap   = (r_baud == c_BAUD_LAST);
    // Ready while idle, and in the last cycle of the stop bit for back-to-back bytes
    assign ready    = !r_active || ((r_state == STOP) && w_wrap);
    assign w_accept = valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= START;
            r_active  <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_active  <= w_active_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_data    <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active;
        w_bit_idx_nxt = r_bit_idx;
        w_data_nxt    = r_data;
        w_baud_nxt    = '0;
        if (r_active && !w_wrap) begin
            w_baud_nxt = r_baud + c_BAUD_W'(1);
        end

        if (w_accept) begin
            w_active_nxt  = 1'b1;
            w_state_nxt   = START;
            w_bit_idx_nxt = '0;
            w_data_nxt    = data;
            w_baud_nxt    = '0;
        end else if (r_active && w_wrap) begin
            case (r_state)
                START: begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = '0;
                end
                DATA: begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    w_active_nxt = 1'b0;
                end
                default: begin
                    w_active_nxt = 1'b0;
                    w_state_nxt  = START;
                end
            endcase
        end
    end

    // Line level is a pure decode of registered state
    always_comb begin
        w_tx = 1'b1;
        if (r_active) begin
            case (r_state)
                START:   w_tx = 1'b0;
                DATA:    w_tx = r_data[r_bit_idx];
                default: w_tx = 1'b1;
            endcase
        end
    end

    assign tx = w_tx;

endmodule
`default_nettype wire

// File: rtl/debug_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : debug_uart_tx
// Description : Debug-port frame transmitter. On trigger (while idle) snaps
//               the debug bytes, computes their XOR checksum and sends
//               SYNC_BYTE, port1..port7, checksum as back-to-back 8N1 bytes.
// Ports       : clk, reset (sync, active-high), trigger, ports_in[55:0]
//               (port1 = [7:0] ... port7 = [55:48])                -> inputs
//               tx (UART line), busy, frame_done (1-cycle pulse)    -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module debug_uart_tx
    import debug_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         NUM_PORTS    = debug_pkg::NUM_PORTS,
    parameter logic [7:0] SYNC_BYTE    = debug_pkg::SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic [8*NUM_PORTS-1:0] ports_in,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done
);

    // Byte index 0 = sync, 1..NUM_PORTS = payload, NUM_PORTS+1 = checksum
    localparam int                 c_IDX_W    = $clog2(NUM_PORTS + 2);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_PORTS + 1);

    frame_state_t           r_state;
    logic [c_IDX_W-1:0]     r_byte_idx;
    logic [8*NUM_PORTS-1:0] r_snapshot;
    logic [7:0]             r_checksum;

    frame_state_t           w_state_nxt;
    logic [c_IDX_W-1:0]     w_idx_nxt;
    logic [c_IDX_W-1:0]     w_next_idx;
    logic                   w_capture;
    logic                   w_valid;
    logic [7:0]             w_tx_data;
    logic [7:0]             w_next_byte;
    logic [7:0]             w_checksum;
    logic                   w_byte_ready;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .reset (reset),
        .data  (w_tx_data),
        .valid (w_valid),
        .ready (w_byte_ready),
        .tx    (tx)
    );

    // Checksum is taken from live inputs so it is ready in the capture cycle
    always_comb begin
        w_checksum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_checksum = w_checksum ^ ports_in[8*i +: 8];
        end
    end

    always_comb begin
        w_next_idx  = r_byte_idx + c_IDX_W'(1);
        w_next_byte = r_checksum;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_next_idx == c_IDX_W'(i + 1)) begin
                w_next_byte = r_snapshot[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_snapshot <= '0;
            r_checksum <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_idx_nxt;
            if (w_capture) begin
                r_snapshot <= ports_in;
                r_checksum <= w_checksum;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_byte_idx;
        w_capture   = 1'b0;
        w_valid     = 1'b0;
        w_tx_data   = SYNC_BYTE;
        case (r_state)
            IDLE: begin
                // Serializer is idle here, so the sync byte is taken on this edge
                if (trigger) begin
                    w_capture   = 1'b1;
                    w_valid     = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_byte_ready) begin
                    if (r_byte_idx == c_LAST_IDX) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_valid   = 1'b1;
                        w_tx_data = w_next_byte;
                        w_idx_nxt = w_next_idx;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy       = (r_state == SEND);
    assign frame_done = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
Serial transmitter that carries the cpu debug ports back to the host-side serial port debugger. On a trigger it snapshots the seven 8-bit debug bytes and sends them as one framed UART packet: sync byte, seven payload bytes, XOR checksum. It sits at the board top, between the cpu debug_port1..7 outputs and the FPGA UART TX pin. It is the transmitting end of the debug link the host receiver decodes.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (must be >= 2)
NUM_PORTS, 7, number of debug bytes per frame (fixed at 7 for this design)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
trigger  input  1  single-cycle request to capture and send a frame
ports_in  input  56  debug bytes; port1 = [7:0], port2 = [15:8], ... port7 = [55:48]
tx  output  1  UART line, 8N1, LSB first, idles high
busy  output  1  high from the cycle after an accepted trigger until the frame completes
frame_done  output  1  one-cycle pulse when the last stop bit has finished

Behaviour:
- Reset values: tx=1, busy=0, frame_done=0, FSM=IDLE, bit/byte counters=0. Reset has priority over every other input.
- Reset mid-frame: tx returns high on the next edge. The frame is abandoned, no frame_done pulse is issued, and nothing resumes afterwards.
- Accept: when trigger=1 in IDLE at edge t:
  - ports_in is latched into an internal 7-byte snapshot.
  - The checksum is computed over the snapshot as the XOR of all 7 bytes.
  - From t+1: busy=1 and tx=0 (start bit of SYNC_BYTE).
  - ports_in changes after edge t do not affect the frame.
- Trigger while busy (including the frame_done cycle) is ignored. There is no queueing.
- Frame order: SYNC_BYTE, port1, port2, ..., port7, checksum. That is 9 bytes, back to back, with no idle gap between a stop bit and the next start bit.
- Byte format: start (0), d0..d7, stop (1). Each bit is held for exactly CLKS_PER_BIT cycles. Each byte lasts 10*CLKS_PER_BIT cycles.
- Frame length: 90*CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the end of the last stop bit.
- Completion: in the cycle after the last stop-bit period, frame_done=1 and busy=0 (same edge), tx=1. The FSM is back in IDLE. A trigger in that frame_done cycle is ignored; the earliest accepted trigger is the next cycle.
- Top-level FSM: IDLE -> SEND (byte_idx 0..8) -> DONE (1 cycle) -> IDLE.
- Byte sub-FSM: START -> DATA (bit_idx 0..7) -> STOP. After STOP it returns to START if more bytes remain, otherwise it ends the frame.
- Baud counter: counts 0..CLKS_PER_BIT-1, sized $clog2(CLKS_PER_BIT). It wraps on the bit boundary and the bit/state advances on the wrap.
- Checksum arithmetic: 8-bit XOR only, no carry. SYNC_BYTE is not included in the checksum.

Decomposition:
- Shared package debug_pkg holds:
  - SYNC_BYTE and NUM_PORTS constants
  - the frame state enum (IDLE, SEND, DONE)
  - the byte state enum (START, DATA, STOP)
- Sub-module uart_tx_byte:
  - Inputs: clk, reset, data[7:0], valid.
  - Outputs: ready, tx.
  - Parameter: CLKS_PER_BIT.
  - Accepts a byte when valid&ready and serializes it 8N1. ready rises in the final stop-bit cycle so the next byte's start bit follows with no gap.
- debug_uart_tx owns the snapshot, the checksum, the byte sequencing, busy and frame_done.

Test Plan (CLKS_PER_BIT=4 for all scenarios):
- Reset idle: assert reset for 3 cycles, then release -> tx=1, busy=0, frame_done=0. Hold 50 cycles with trigger=0 -> tx stays 1.
- Basic frame: ports_in bytes 01..07, trigger pulse -> decoded bytes A5,01,02,03,04,05,06,07,00 (checksum 00). The first start bit begins 1 cycle after trigger. frame_done pulses exactly 360 cycles after the first tx=0 cycle.
- Checksum/snapshot: all bytes FF, trigger, then change ports_in to 00 on the next cycle -> payload FF x7, checksum FF, ports_in change ignored. Bit timing: every bit held exactly 4 cycles.
- Trigger while busy: trigger at cycle 0 and again at cycles 50 and 200 -> exactly one frame is sent. A trigger in the frame_done cycle is ignored. A trigger one cycle later starts a second frame.
- Reset mid-frame: assert reset during bit 3 of port2 -> tx=1 and busy=0 after the next edge, no frame_done pulse. A new trigger afterwards yields a complete, correct frame starting with A5.
- LSB-first check: port1=8'h01, other bytes 00 -> the port1 data bits on the line are 1,0,0,0,0,0,0,0. Checksum 01.
